// File: rtl/softex_cast_in_packer.sv
// softex_cast_in_packer
// Packs RATIO consecutive partially-filled cast beats (only the low LANES_IN
// FP lanes valid) into one fully populated FP beat. With casting disabled the
// block is a single registered stage that forwards beats unchanged.
// One output register: the input is ready whenever that register is empty or
// being drained in the same cycle. Data never passes combinationally from
// input to output.

module softex_cast_in_packer #(
    parameter int unsigned DATA_WIDTH = 288,
    parameter int unsigned FP_WIDTH   = 16,
    parameter int unsigned INT_WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    last_i,

    // upstream (cast stage output)
    input  logic                    stream_i_valid_i,
    output logic                    stream_i_ready_o,
    input  logic [DATA_WIDTH-1:0]   stream_i_data_i,
    input  logic [DATA_WIDTH/8-1:0] stream_i_strb_i,

    // downstream (packed output)
    output logic                    stream_o_valid_o,
    input  logic                    stream_o_ready_i,
    output logic [DATA_WIDTH-1:0]   stream_o_data_o,
    output logic [DATA_WIDTH/8-1:0] stream_o_strb_o
);

    // The top 32 bits of the stream are padding and never carry lane data.
    localparam int unsigned ACTUAL_DW = DATA_WIDTH - 32;
    localparam int unsigned LANES_OUT = ACTUAL_DW / FP_WIDTH;
    localparam int unsigned LANES_IN  = (INT_WIDTH > FP_WIDTH) ? ACTUAL_DW / INT_WIDTH : LANES_OUT;
    localparam int unsigned RATIO     = LANES_OUT / LANES_IN;

    localparam int unsigned SEG_W     = LANES_IN * FP_WIDTH;   // data bits per slot
    localparam int unsigned SEG_SW    = SEG_W / 8;             // strobe bits per slot
    localparam int unsigned ACC_SW    = ACTUAL_DW / 8;
    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned PAD_W     = DATA_WIDTH - ACTUAL_DW;
    localparam int unsigned PAD_SW    = STRB_W - ACC_SW;
    localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Reject configurations where slots would not tile the accumulator.
    generate
        if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0)) begin : g_bad_ratio
            $error("softex_cast_in_packer: RATIO must be a power of two >= 1");
        end
        if ((LANES_IN == 0) || ((LANES_OUT % LANES_IN) != 0)) begin : g_bad_lanes
            $error("softex_cast_in_packer: LANES_OUT must be a multiple of LANES_IN");
        end
        if ((DATA_WIDTH <= 32) || ((ACTUAL_DW % FP_WIDTH) != 0) || ((SEG_W % 8) != 0)) begin : g_bad_width
            $error("softex_cast_in_packer: unsupported DATA_WIDTH / FP_WIDTH combination");
        end
    endgenerate

    // State
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic [ACTUAL_DW-1:0]  acc_data_q,  acc_data_d;
    logic [ACC_SW-1:0]     acc_strb_q,  acc_strb_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [STRB_W-1:0]     out_strb_q,  out_strb_d;
    logic                  out_valid_q, out_valid_d;

    // Datapath helpers
    logic                  accept;
    logic                  last_slot;
    logic [SEG_W-1:0]      seg_data;
    logic [SEG_SW-1:0]     seg_strb;
    logic [ACTUAL_DW-1:0]  merged_data;
    logic [ACC_SW-1:0]     merged_strb;

    assign stream_i_ready_o = !out_valid_q || stream_o_ready_i;
    assign accept           = stream_i_valid_i && stream_i_ready_o;

    assign stream_o_valid_o = out_valid_q;
    assign stream_o_data_o  = out_data_q;
    assign stream_o_strb_o  = out_strb_q;

    // Only the low LANES_IN lanes of a cast beat carry data.
    assign seg_data  = stream_i_data_i[SEG_W-1:0];
    assign seg_strb  = stream_i_strb_i[SEG_SW-1:0];
    assign last_slot = (cnt_q == CNT_W'(RATIO - 1));

    // Accumulator with the incoming segment dropped into slot cnt.
    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slot
            logic slot_hit;
            assign slot_hit = (cnt_q == CNT_W'(gi));
            assign merged_data[gi*SEG_W +: SEG_W]   = slot_hit ? seg_data : acc_data_q[gi*SEG_W +: SEG_W];
            assign merged_strb[gi*SEG_SW +: SEG_SW] = slot_hit ? seg_strb : acc_strb_q[gi*SEG_SW +: SEG_SW];
        end
    endgenerate

    // Next-state: pack, emit on last slot / tile end, or forward in bypass.
    always_comb begin
        cnt_d       = cnt_q;
        acc_data_d  = acc_data_q;
        acc_strb_d  = acc_strb_q;
        out_data_d  = out_data_q;
        out_strb_d  = out_strb_q;
        // A pending beat drains when downstream is ready.
        out_valid_d = out_valid_q && !stream_o_ready_i;

        if (accept) begin
            if (enable_i) begin
                if (last_slot || last_i) begin
                    out_data_d  = {{PAD_W{1'b0}}, merged_data};
                    out_strb_d  = {{PAD_SW{1'b0}}, merged_strb};
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    acc_data_d  = '0;
                    acc_strb_d  = '0;
                end else begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    acc_data_d  = merged_data;
                    acc_strb_d  = merged_strb;
                end
            end else begin
                // Bypass; any partial pack left over from an illegal mode
                // switch is dropped so the stream cannot lock up.
                out_data_d  = stream_i_data_i;
                out_strb_d  = stream_i_strb_i;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_data_d  = '0;
                acc_strb_d  = '0;
            end
        end
    end

    // State registers; clear wins over a simultaneous accept.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_q       <= '0;
            acc_data_q  <= '0;
            acc_strb_q  <= '0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_data_q  <= acc_data_d;
            acc_strb_q  <= acc_strb_d;
            out_data_q  <= out_data_d;
            out_strb_q  <= out_strb_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_softex_cast_in_packer.sv
// Directed testbench for softex_cast_in_packer (DATA_WIDTH=288, INT=32, FP=16,
// RATIO=2). Expected beats are built from the input vectors by a small
// packing function; a negedge monitor records every output handshake.

module tb_softex_cast_in_packer;

    localparam int DW = 288;
    localparam int SW = 36;

    logic          clk;
    logic          clear;
    logic          enable;
    logic          last;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_strb;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_strb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stalls   = 0;

    logic [DW-1:0] mon_d[$];
    logic [SW-1:0] mon_s[$];
    int            mon_c[$];

    softex_cast_in_packer #(
        .DATA_WIDTH (288),
        .FP_WIDTH   (16),
        .INT_WIDTH  (32)
    ) dut (
        .clk_i            (clk),
        .clear_i          (clear),
        .enable_i         (enable),
        .last_i           (last),
        .stream_i_valid_i (in_valid),
        .stream_i_ready_o (in_ready),
        .stream_i_data_i  (in_data),
        .stream_i_strb_i  (in_strb),
        .stream_o_valid_o (out_valid),
        .stream_o_ready_i (out_ready),
        .stream_o_data_o  (out_data),
        .stream_o_strb_o  (out_strb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output handshake.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            mon_d.push_back(out_data);
            mon_s.push_back(out_strb);
            mon_c.push_back(cyc);
            $display("[%0d] out beat data=%h strb=%h", cyc, out_data, out_strb);
        end
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane i of the pattern holds {seed, i}, so lane placement is obvious.
    function automatic logic [DW-1:0] pat(input logic [15:0] s);
        logic [DW-1:0] d;
        for (int i = 0; i < 9; i++) d[i*32 +: 32] = {s, 16'(i)};
        return d;
    endfunction

    function automatic logic [DW-1:0] pack_d(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit has_b);
        logic [DW-1:0] d;
        d = '0;
        d[127:0] = a[127:0];
        if (has_b) d[255:128] = b[127:0];
        return d;
    endfunction

    function automatic logic [SW-1:0] pack_s(input logic [SW-1:0] a, input logic [SW-1:0] b, input bit has_b);
        logic [SW-1:0] s;
        s = '0;
        s[15:0] = a[15:0];
        if (has_b) s[31:16] = b[15:0];
        return s;
    endfunction

    // Present one beat and hold it until accepted (bounded). Returns at posedge+1.
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l, input logic en);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_strb  = s;
        last     = l;
        enable   = en;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        $display("[%0d] in beat data=%h strb=%h last=%0b en=%0b accepted=%0b", cyc, d, s, l, en, ok);
        check_val("send_accept", DW'(ok), DW'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        last     = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_d.delete();
        mon_s.delete();
        mon_c.delete();
    endtask

    task automatic check_out(input string tag, input int idx, input logic [DW-1:0] ed, input logic [SW-1:0] es);
        logic [DW-1:0] gd;
        logic [SW-1:0] gs;
        gd = '0;
        gs = '0;
        if (idx < mon_d.size()) begin
            gd = mon_d[idx];
            gs = mon_s[idx];
        end
        check_val($sformatf("%s_data%0d", tag, idx), gd, ed);
        check_val($sformatf("%s_strb%0d", tag, idx), DW'(gs), DW'(es));
    endtask

    logic [DW-1:0] a, b, c1, c2, c3, x, sd[8];
    logic [SW-1:0] sa, sb, ss[8];

    initial begin
        clear     = 1'b1;
        enable    = 1'b1;
        last      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_strb   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_out_valid", DW'(out_valid), DW'(0));
        check_val("rst_in_ready",  DW'(in_ready),  DW'(1));
        check_val("rst_out_data",  out_data, '0);
        check_val("rst_out_strb",  DW'(out_strb), '0);
        @(posedge clk);
        #1;

        // 1. Basic pair
        clear_mon();
        a  = pat(16'hA000);
        b  = pat(16'hB000);
        sa = 36'hF_1234_ABCD;
        sb = 36'h5_8765_4321;
        send_beat(a, sa, 1'b0, 1'b1);
        check_val("t1_no_early_valid", DW'(out_valid), DW'(0));
        send_beat(b, sb, 1'b0, 1'b1);
        check_val("t1_latency_valid", DW'(out_valid), DW'(1));
        idle(3);
        check_val("t1_count", DW'(mon_d.size()), DW'(1));
        check_out("t1", 0, pack_d(a, b, 1'b1), pack_s(sa, sb, 1'b1));

        // 2. Odd tile, last on third beat (slot 0)
        clear_mon();
        c1 = pat(16'hC001);
        c2 = pat(16'hC002);
        c3 = pat(16'hC003);
        send_beat(c1, 36'hF_FFFF_FFFF, 1'b0, 1'b1);
        send_beat(c2, 36'hF_FFFF_FFFF, 1'b0, 1'b1);
        send_beat(c3, 36'hF_FFFF_FFFF, 1'b1, 1'b1);
        idle(3);
        check_val("t2_count", DW'(mon_d.size()), DW'(2));
        check_out("t2", 0, pack_d(c1, c2, 1'b1), pack_s(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1));
        check_out("t2", 1, pack_d(c3, '0, 1'b0), pack_s(36'hF_FFFF_FFFF, '0, 1'b0));

        // 3. Backpressure
        clear_mon();
        out_ready = 1'b0;
        a = pat(16'hD001);
        b = pat(16'hD002);
        send_beat(a, 36'h0_0000_FF0F, 1'b0, 1'b1);
        send_beat(b, 36'h0_0000_F0FF, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = pat(16'hD003);
        in_strb  = 36'hF_FFFF_FFFF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val($sformatf("t3_hold_valid%0d", k), DW'(out_valid), DW'(1));
            check_val($sformatf("t3_hold_ready%0d", k), DW'(in_ready), DW'(0));
            check_val($sformatf("t3_hold_data%0d", k), out_data, pack_d(a, b, 1'b1));
            check_val($sformatf("t3_hold_strb%0d", k), DW'(out_strb),
                      DW'(pack_s(36'h0_0000_FF0F, 36'h0_0000_F0FF, 1'b1)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_beat(pat(16'hD003), 36'hF_FFFF_FFFF, 1'b0, 1'b1);
        send_beat(pat(16'hD004), 36'hF_FFFF_FFFF, 1'b0, 1'b1);
        idle(3);
        check_val("t3_count", DW'(mon_d.size()), DW'(2));
        check_out("t3", 0, pack_d(a, b, 1'b1), pack_s(36'h0_0000_FF0F, 36'h0_0000_F0FF, 1'b1));
        check_out("t3", 1, pack_d(pat(16'hD003), pat(16'hD004), 1'b1),
                  pack_s(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 1'b1));

        // 4. Bypass
        clear_mon();
        x = pat(16'hE0E0);
        send_beat(x, 36'hF_FFFF_FFFF, 1'b1, 1'b0);
        check_val("t4_latency_valid", DW'(out_valid), DW'(1));
        idle(3);
        enable = 1'b1;
        check_val("t4_count", DW'(mon_d.size()), DW'(1));
        check_out("t4", 0, x, 36'hF_FFFF_FFFF);

        // 5. Clear mid-pack
        clear_mon();
        send_beat(pat(16'hAAAA), 36'hF_FFFF_FFFF, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = pat(16'hBBBB);
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_clear_valid", DW'(out_valid), DW'(0));
        a = pat(16'hC5C5);
        b = pat(16'hD5D5);
        send_beat(a, 36'h0_0000_1111, 1'b0, 1'b1);
        send_beat(b, 36'h0_0000_2222, 1'b0, 1'b1);
        idle(3);
        check_val("t5_count", DW'(mon_d.size()), DW'(1));
        check_out("t5", 0, pack_d(a, b, 1'b1), pack_s(36'h0_0000_1111, 36'h0_0000_2222, 1'b1));

        // 6. Streaming, back-to-back, one beat with all-zero strobe
        clear_mon();
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            sd[i] = pat(16'h6000 + 16'(i));
            ss[i] = (i == 5) ? 36'h0 : {20'hABCDE, 16'(16'h1111 * (i + 1))};
        end
        for (int i = 0; i < 8; i++) send_beat(sd[i], ss[i], 1'b0, 1'b1);
        idle(3);
        check_val("t6_stalls", DW'(stalls), DW'(0));
        check_val("t6_count", DW'(mon_d.size()), DW'(4));
        for (int j = 0; j < 4; j++)
            check_out("t6", j, pack_d(sd[2*j], sd[2*j+1], 1'b1), pack_s(ss[2*j], ss[2*j+1], 1'b1));
        for (int j = 0; j < 3; j++)
            check_val($sformatf("t6_spacing%0d", j),
                      DW'((j + 1 < mon_c.size()) ? (mon_c[j+1] - mon_c[j]) : 0), DW'(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
